// File: rtl/enc_dec_cfg_sequencer.sv
// Host-side sequencer for the encrypt/decrypt wrapper: forwards plaintext bytes and
// commits configuration words only once the wrapper pipeline has fully drained.
module enc_dec_cfg_sequencer #(
    parameter int MAX_INFLIGHT  = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_valid,
    input  logic [7:0]       host_data,
    output logic             host_ready,
    input  logic             host_cfg_valid,
    input  logic [63:0]      host_cfg_data,
    output logic             host_cfg_ready,
    input  logic             decrypt_valid_out,
    output logic             enable,
    output logic [7:0]       data_in_encrypt,
    output logic             cfg_wen,
    output logic [63:0]      cfg_data_in,
    output logic             busy,
    output logic [CNT_W-1:0] inflight,
    output logic [7:0]       cfg_count,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t            state_r;
    logic [63:0]       pending_r;
    logic [3:0]        settle_r;
    logic [CNT_W-1:0]  inflight_r;
    logic              enable_r;
    logic [7:0]        data_r;
    logic              cfg_wen_r;
    logic [63:0]       cfg_data_r;
    logic [7:0]        cfg_count_r;
    logic              busy_r;
    logic              err_r;

    logic              run_s;
    logic              byte_acc_s;
    logic              cfg_acc_s;
    logic              room_s;

    // Handshake readiness; a configuration word wins over a simultaneous byte.
    always_comb begin
        run_s          = (state_r == ST_RUN);
        room_s         = (inflight_r < CNT_W'(MAX_INFLIGHT));
        host_cfg_ready = run_s;
        host_ready     = run_s && !host_cfg_valid && room_s;
        cfg_acc_s      = host_cfg_valid && run_s;
        byte_acc_s     = host_valid && host_ready;
    end

    // Byte path into the wrapper; data holds its last value while enable is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_r <= 1'b0;
            data_r   <= 8'h00;
        end else begin
            enable_r <= byte_acc_s;
            if (byte_acc_s) begin
                data_r <= host_data;
            end else begin
                data_r <= data_r;
            end
        end
    end

    // In-flight accounting; a return with nothing outstanding flags a sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_r <= {CNT_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            if (decrypt_valid_out && (inflight_r == {CNT_W{1'b0}})) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            if (byte_acc_s && !decrypt_valid_out) begin
                inflight_r <= inflight_r + CNT_W'(1'b1);
            end else if (decrypt_valid_out && !byte_acc_s && (inflight_r != {CNT_W{1'b0}})) begin
                inflight_r <= inflight_r - CNT_W'(1'b1);
            end else begin
                inflight_r <= inflight_r;
            end
        end
    end

    // Configuration sequencing: drain, commit for one cycle, then settle before resuming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RUN;
            pending_r   <= 64'h0;
            settle_r    <= 4'd0;
            cfg_wen_r   <= 1'b0;
            cfg_data_r  <= 64'h0;
            cfg_count_r <= 8'd0;
            busy_r      <= 1'b0;
        end else begin
            cfg_wen_r <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (cfg_acc_s) begin
                        pending_r <= host_cfg_data;
                        busy_r    <= 1'b1;
                        state_r   <= ST_DRAIN;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Outputs are registered, so the commit is launched on entry to LOAD.
                    if ((inflight_r == {CNT_W{1'b0}}) && !enable_r) begin
                        cfg_wen_r   <= 1'b1;
                        cfg_data_r  <= pending_r;
                        cfg_count_r <= cfg_count_r + 8'd1;
                        state_r     <= ST_LOAD;
                    end else begin
                        state_r     <= ST_DRAIN;
                    end
                end
                ST_LOAD: begin
                    settle_r <= 4'(SETTLE_CYCLES);
                    state_r  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    settle_r <= settle_r - 4'd1;
                    if (settle_r <= 4'd1) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_SETTLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    assign enable          = enable_r;
    assign data_in_encrypt = data_r;
    assign cfg_wen         = cfg_wen_r;
    assign cfg_data_in     = cfg_data_r;
    assign busy            = busy_r;
    assign inflight        = inflight_r;
    assign cfg_count       = cfg_count_r;
    assign err             = err_r;

endmodule

// File: tb/tb_enc_dec_cfg_sequencer.sv
// Directed bench for enc_dec_cfg_sequencer: byte stream, full boundary, config
// commit ordering, underflow and reset abort, all against hand-computed values.
module tb_enc_dec_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        host_valid = 1'b0;
    logic [7:0]  host_data = 8'h00;
    logic        host_ready;
    logic        host_cfg_valid = 1'b0;
    logic [63:0] host_cfg_data = 64'h0;
    logic        host_cfg_ready;
    logic        decrypt_valid_out = 1'b0;
    logic        enable;
    logic [7:0]  data_in_encrypt;
    logic        cfg_wen;
    logic [63:0] cfg_data_in;
    logic        busy;
    logic [3:0]  inflight;
    logic [7:0]  cfg_count;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] CFG_A = 64'h00AA_BBCC_DDEE_FF01;

    enc_dec_cfg_sequencer dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .host_cfg_valid(host_cfg_valid), .host_cfg_data(host_cfg_data),
        .host_cfg_ready(host_cfg_ready), .decrypt_valid_out(decrypt_valid_out),
        .enable(enable), .data_in_encrypt(data_in_encrypt), .cfg_wen(cfg_wen),
        .cfg_data_in(cfg_data_in), .busy(busy), .inflight(inflight),
        .cfg_count(cfg_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL rst_enable: got %0h expected 0", enable); end
        n_checks++; if (data_in_encrypt !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %0h expected 0", data_in_encrypt); end
        n_checks++; if (cfg_wen !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_wen: got %0h expected 0", cfg_wen); end
        n_checks++; if (cfg_data_in !== 64'h0) begin n_fail++; $display("FAIL rst_cfg_data: got %0h expected 0", cfg_data_in); end
        n_checks++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL rst_inflight: got %0d expected 0", inflight); end
        n_checks++; if (cfg_count !== 8'd0) begin n_fail++; $display("FAIL rst_cfg_count: got %0d expected 0", cfg_count); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0h expected 0", err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0h expected 0", busy); end
        n_checks++; if (host_cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cfg_ready: got %0h expected 1", host_cfg_ready); end
        host_valid = 1'b1;
        #1;
        n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL rst_host_ready: got %0h expected 1", host_ready); end
        host_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_byte_stream();
        logic       hv [8]      = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] hd [8]      = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic       dv [8]      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       exp_en [8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] exp_d [8]   = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33};
        logic [3:0] exp_inf [8] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
        for (int j = 0; j < 8; j++) begin
            host_valid        = hv[j];
            host_data         = hd[j];
            decrypt_valid_out = dv[j];
            tick();
            n_checks++; if (enable !== exp_en[j]) begin n_fail++; $display("FAIL stream_enable[%0d]: got %0h expected %0h", j, enable, exp_en[j]); end
            n_checks++; if (data_in_encrypt !== exp_d[j]) begin n_fail++; $display("FAIL stream_data[%0d]: got %0h expected %0h", j, data_in_encrypt, exp_d[j]); end
            n_checks++; if (inflight !== exp_inf[j]) begin n_fail++; $display("FAIL stream_inflight[%0d]: got %0d expected %0d", j, inflight, exp_inf[j]); end
        end
        host_valid = 1'b0;
        decrypt_valid_out = 1'b0;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL stream_err: got %0h expected 0", err); end
    endtask

    task automatic test_full_boundary();
        for (int i = 0; i < 8; i++) begin
            host_valid = 1'b1;
            host_data  = 8'h40 + 8'(i);
            #1;
            n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_fill[%0d]: got %0h expected 1", i, host_ready); end
            tick();
        end
        host_data = 8'h99;
        #1;
        n_checks++; if (inflight !== 4'd8) begin n_fail++; $display("FAIL full_inflight: got %0d expected 8", inflight); end
        n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_low: got %0h expected 0", host_ready); end
        n_checks++; if (data_in_encrypt !== 8'h47) begin n_fail++; $display("FAIL full_last_byte: got %0h expected 47", data_in_encrypt); end
        decrypt_valid_out = 1'b1;
        tick();
        n_checks++; if (inflight !== 4'd7) begin n_fail++; $display("FAIL full_after_return: got %0d expected 7", inflight); end
        n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL full_no_accept: got %0h expected 0", enable); end
        n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_again: got %0h expected 1", host_ready); end
        host_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        decrypt_valid_out = 1'b0;
        n_checks++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL full_drained: got %0d expected 0", inflight); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL full_err: got %0h expected 0", err); end
    endtask

    task automatic test_simultaneous();
        logic       dv [6]       = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       exp_wen [6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       exp_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] exp_inf [6]  = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        int wen_count = 0;
        host_valid = 1'b1; host_data = 8'hA1; tick();
        host_data = 8'hA2; tick();
        host_data = 8'h55; host_cfg_valid = 1'b1; host_cfg_data = CFG_A;
        #1;
        n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL simul_host_ready: got %0h expected 0", host_ready); end
        n_checks++; if (host_cfg_ready !== 1'b1) begin n_fail++; $display("FAIL simul_cfg_ready: got %0h expected 1", host_cfg_ready); end
        tick();
        host_cfg_valid = 1'b0; host_cfg_data = 64'h0;
        #1;
        n_checks++; if (enable !== 1'b0) begin n_fail++; $display("FAIL simul_byte_dropped: got %0h expected 0", enable); end
        n_checks++; if (data_in_encrypt !== 8'hA2) begin n_fail++; $display("FAIL simul_data_held: got %0h expected a2", data_in_encrypt); end
        n_checks++; if (inflight !== 4'd2) begin n_fail++; $display("FAIL simul_inflight: got %0d expected 2", inflight); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL simul_busy_drain: got %0h expected 1", busy); end
        n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL simul_drain_ready: got %0h expected 0", host_ready); end
        n_checks++; if (host_cfg_ready !== 1'b0) begin n_fail++; $display("FAIL simul_drain_cfg_ready: got %0h expected 0", host_cfg_ready); end
        host_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            decrypt_valid_out = dv[j];
            tick();
            if (cfg_wen === 1'b1) wen_count++;
            n_checks++; if (cfg_wen !== exp_wen[j]) begin n_fail++; $display("FAIL simul_cfg_wen[%0d]: got %0h expected %0h", j, cfg_wen, exp_wen[j]); end
            n_checks++; if (busy !== exp_busy[j]) begin n_fail++; $display("FAIL simul_busy[%0d]: got %0h expected %0h", j, busy, exp_busy[j]); end
            n_checks++; if (inflight !== exp_inf[j]) begin n_fail++; $display("FAIL simul_inflight[%0d]: got %0d expected %0d", j, inflight, exp_inf[j]); end
            if (j == 2) begin
                n_checks++; if (cfg_data_in !== CFG_A) begin n_fail++; $display("FAIL simul_cfg_data_load: got %0h expected %0h", cfg_data_in, CFG_A); end
                n_checks++; if (cfg_count !== 8'd1) begin n_fail++; $display("FAIL simul_cfg_count_load: got %0d expected 1", cfg_count); end
            end
        end
        decrypt_valid_out = 1'b0;
        n_checks++; if (wen_count !== 1) begin n_fail++; $display("FAIL simul_wen_pulses: got %0d expected 1", wen_count); end
        n_checks++; if (cfg_data_in !== CFG_A) begin n_fail++; $display("FAIL simul_cfg_data_held: got %0h expected %0h", cfg_data_in, CFG_A); end
        n_checks++; if (cfg_count !== 8'd1) begin n_fail++; $display("FAIL simul_cfg_count: got %0d expected 1", cfg_count); end
        host_valid = 1'b1;
        #1;
        n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL simul_run_resumed: got %0h expected 1", host_ready); end
        host_valid = 1'b0;
    endtask

    task automatic test_underflow();
        decrypt_valid_out = 1'b1;
        tick();
        decrypt_valid_out = 1'b0;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL underflow_err: got %0h expected 1", err); end
        n_checks++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL underflow_inflight: got %0d expected 0", inflight); end
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got %0h expected 1", err); end
    endtask

    task automatic test_reset_drain();
        int wen_seen = 0;
        host_valid = 1'b1; host_data = 8'h77; tick();
        host_valid = 1'b0; host_cfg_valid = 1'b1; host_cfg_data = 64'h1122_3344_5566_7788; tick();
        host_cfg_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstdrain_busy: got %0h expected 1", busy); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstdrain_busy_clr: got %0h expected 0", busy); end
        n_checks++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL rstdrain_inflight: got %0d expected 0", inflight); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstdrain_err: got %0h expected 0", err); end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cfg_wen !== 1'b0) wen_seen++;
        end
        n_checks++; if (wen_seen !== 0) begin n_fail++; $display("FAIL rstdrain_no_wen: got %0d pulses expected 0", wen_seen); end
        n_checks++; if (cfg_data_in !== 64'h0) begin n_fail++; $display("FAIL rstdrain_cfg_data: got %0h expected 0", cfg_data_in); end
        n_checks++; if (cfg_count !== 8'd0) begin n_fail++; $display("FAIL rstdrain_cfg_count: got %0d expected 0", cfg_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstdrain_busy_after: got %0h expected 0", busy); end
        n_checks++; if (host_cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rstdrain_cfg_ready: got %0h expected 1", host_cfg_ready); end
    endtask

    initial begin
        test_reset();
        test_byte_stream();
        test_full_boundary();
        test_simultaneous();
        test_underflow();
        test_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enc_dec_cfg_sequencer.md
# enc_dec_cfg_sequencer

Sequences host traffic and configuration updates into the encrypt/decrypt system wrapper. It accepts plaintext bytes and 64-bit configuration words from a host over valid/ready handshakes and drives the wrapper's `enable`/`data_in_encrypt` and `cfg_wen`/`cfg_data_in` ports. A new configuration is committed only after every in-flight byte has left the decrypt unit, so keys, rotation and permutation never change mid-stream. Traffic then resumes after a settle window.

## Interface
- `MAX_INFLIGHT`, default 8: maximum bytes issued but not yet returned by `decrypt_valid_out`.
- `SETTLE_CYCLES`, default 2: idle cycles after `cfg_wen` before traffic resumes; legal range 1..15.
- `CNT_W`, default 4: width of the in-flight counter; must hold `MAX_INFLIGHT`.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `host_valid` in 1: host plaintext byte valid.
- `host_data` in 8: host plaintext byte.
- `host_ready` out 1: byte accepted when `host_valid && host_ready`.
- `host_cfg_valid` in 1: host configuration word valid.
- `host_cfg_data` in 64: configuration word, in the wrapper's `cfg_data_in` layout.
- `host_cfg_ready` out 1: word accepted when `host_cfg_valid && host_cfg_ready`.
- `decrypt_valid_out` in 1: return pulse from the wrapper, one per completed byte.
- `enable` out 1: drives wrapper `enable`; registered.
- `data_in_encrypt` out 8: drives wrapper `data_in_encrypt`; registered.
- `cfg_wen` out 1: drives wrapper `cfg_wen`; single-cycle pulse.
- `cfg_data_in` out 64: drives wrapper `cfg_data_in`; shadow register, held stable.
- `busy` out 1: high in DRAIN, LOAD and SETTLE.
- `inflight` out CNT_W: current in-flight count.
- `cfg_count` out 8: number of committed configurations; wraps 255 -> 0.
- `err` out 1: sticky flag, set when `decrypt_valid_out` arrives with `inflight == 0`.

## Operation
- **States:** RUN, DRAIN, LOAD, SETTLE. Reset state is RUN.
- **RUN, readiness (combinational):**
  - `host_cfg_ready = (state == RUN)`.
  - `host_ready = (state == RUN) && !host_cfg_valid && (inflight < MAX_INFLIGHT)`.
  - Configuration therefore has priority when both valids are high in the same cycle. The byte is not accepted and the host holds it.
- **Byte accept:** next cycle `enable = 1` and `data_in_encrypt = host_data`. Otherwise `enable = 0` and `data_in_encrypt` holds its last value.
- **Config accept:** `host_cfg_data` is latched into a pending register and the state moves to DRAIN.
- **DRAIN:** no handshakes are accepted. When `inflight == 0 && enable == 0`, move to LOAD.
- **LOAD:**
  - `cfg_data_in <= pending`, and `cfg_wen` is high for exactly this one cycle; both are valid in the same cycle.
  - `cfg_count` increments by 1.
  - Move to SETTLE with the settle counter set to `SETTLE_CYCLES`.
- **SETTLE:** the counter decrements each cycle; on reaching 0, return to RUN. Total SETTLE dwell is `SETTLE_CYCLES` cycles.
- **In-flight counter:**
  - +1 on byte accept, -1 on `decrypt_valid_out`.
  - Both in the same cycle: unchanged.
  - Underflow (decrement at 0): counter stays 0 and `err` is set.
  - `err` is cleared only by `rst`.
- **Counting window:** the counter counts in every state. Returns during DRAIN are what allow exit from DRAIN.
- **Reset values:**
  - `enable = 0`, `data_in_encrypt = 0`, `cfg_wen = 0`, `cfg_data_in = 0`.
  - `inflight = 0`, `cfg_count = 0`, `err = 0`, `busy = 0`, pending register = 0, state = RUN.
- **Reset mid-operation:** a reset asserted in any state aborts it immediately. A pending configuration is discarded and no `cfg_wen` is issued. The wrapper shares `rst`, so its pipeline and config register clear together with this block.

## Timing
- **Byte path:** accept at cycle N -> `enable` high at N+1; `inflight` shows the increment at N+1.
- **Config commit with an empty pipeline:**
  - Accept at N.
  - DRAIN at N+1.
  - LOAD at N+2, with `cfg_wen` and the new `cfg_data_in` at N+2.
  - SETTLE from N+3 to N+2+SETTLE_CYCLES.
  - RUN, with `host_ready` able to assert, at N+3+SETTLE_CYCLES.
- **Config commit with bytes in flight:** LOAD is the cycle after the one in which `inflight` reaches 0 with `enable` low.
- **Full boundary:** at `inflight == MAX_INFLIGHT`, `host_ready` is low. A `decrypt_valid_out` in cycle M re-enables `host_ready` at M+1.
- `busy` is registered from the state and is high exactly during DRAIN, LOAD and SETTLE.

## Test plan
- **Reset values:** assert `rst` mid-cycle, with no clock edge -> all outputs immediately at their reset values; state RUN; `host_ready = 1` once `host_valid` is applied.
- **Byte stream:** stream 0x11, 0x22, 0x33 with `decrypt_valid_out` returned 3 cycles after each `enable` -> `data_in_encrypt` shows each byte one cycle after its accept; `inflight` peaks at 3 and returns to 0.
- **Full boundary:** issue 8 bytes with no returns -> `host_ready` low and `inflight = 8`; one return -> `host_ready` high the next cycle.
- **Simultaneous valids:** `host_cfg_valid` and `host_valid` high together, cfg = 0x00AA_BBCC_DDEE_FF01, 2 bytes in flight -> the byte is not accepted; `cfg_wen` pulses once, one cycle after the second return, with `cfg_data_in` = that value; `cfg_count` = 1; RUN resumes after 2 settle cycles.
- **Underflow:** `decrypt_valid_out` pulse at `inflight = 0` -> `err = 1` and `inflight = 0`; `err` persists until `rst`.
- **Reset during DRAIN:** assert `rst` while a config is pending -> no `cfg_wen`; `cfg_data_in = 0` and `cfg_count = 0` after release.
